// File: rtl/ap_ctrl_perf_monitor.sv
// ap_ctrl_perf_monitor: per-channel ap_ctrl_chain activity counters with indexed readback (optional max latency via AP_PERF_MON_MAXLAT_EN)
module ap_ctrl_perf_monitor #(
  parameter int NUM_CH = 6,
  parameter int CNT_W  = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic [NUM_CH-1:0] iter_end,
  input  logic [NUM_CH-1:0] stall,
  input  logic              finish,
  input  logic              clear,
  input  logic              rd_req,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [2:0]        rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] ch_busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == MAX) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0]       state_q [NUM_CH];
  logic [1:0]       state_d [NUM_CH];
  logic [CNT_W-1:0] inv_q   [NUM_CH];
  logic [CNT_W-1:0] inv_d   [NUM_CH];
  logic [CNT_W-1:0] busy_q  [NUM_CH];
  logic [CNT_W-1:0] busy_d  [NUM_CH];
  logic [CNT_W-1:0] stl_q   [NUM_CH];
  logic [CNT_W-1:0] stl_d   [NUM_CH];
  logic [CNT_W-1:0] iter_q  [NUM_CH];
  logic [CNT_W-1:0] iter_d  [NUM_CH];
  logic [CNT_W-1:0] last_q  [NUM_CH];
  logic [CNT_W-1:0] last_d  [NUM_CH];
  logic [CNT_W-1:0] cur_q   [NUM_CH];
  logic [CNT_W-1:0] cur_d   [NUM_CH];
  logic [CNT_W-1:0] lat_now [NUM_CH];
`ifdef AP_PERF_MON_MAXLAT_EN
  logic [CNT_W-1:0] max_q   [NUM_CH];
  logic [CNT_W-1:0] max_d   [NUM_CH];
`endif
  logic [NUM_CH-1:0] fresh;
  logic [NUM_CH-1:0] run;
  logic              rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;
  logic [CNT_W-1:0]  sel_val;
  logic              ch_ok;

  // A start is accepted from IDLE, or from HOLD in the cycle continue releases it; that cycle counts as latency 1
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      run[i]     = state_q[i] == RUN;
      fresh[i]   = ap_start[i] && (state_q[i] == IDLE || (state_q[i] == HOLD && ap_continue[i]));
      lat_now[i] = fresh[i] ? CNT_W'(1) : sat_inc(cur_q[i]);
      ch_busy[i] = state_q[i] != IDLE;
    end
  end

  // Channel FSMs and counters; clear beats finish, finish freezes everything
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      inv_d[i]   = inv_q[i];
      busy_d[i]  = busy_q[i];
      stl_d[i]   = stl_q[i];
      iter_d[i]  = iter_q[i];
      last_d[i]  = last_q[i];
      cur_d[i]   = cur_q[i];
`ifdef AP_PERF_MON_MAXLAT_EN
      max_d[i]   = max_q[i];
`endif
      if (clear) begin
        state_d[i] = IDLE;
        inv_d[i]   = '0;
        busy_d[i]  = '0;
        stl_d[i]   = '0;
        iter_d[i]  = '0;
        last_d[i]  = '0;
        cur_d[i]   = '0;
`ifdef AP_PERF_MON_MAXLAT_EN
        max_d[i]   = '0;
`endif
      end else if (!finish) begin
        if (run[i] || fresh[i]) begin
          busy_d[i]  = sat_inc(busy_q[i]);
          stl_d[i]   = (run[i] && stall[i]) ? sat_inc(stl_q[i]) : stl_q[i];
          iter_d[i]  = (run[i] && iter_end[i]) ? sat_inc(iter_q[i]) : iter_q[i];
          cur_d[i]   = lat_now[i];
          state_d[i] = RUN;
          if (ap_done[i]) begin
            inv_d[i]   = sat_inc(inv_q[i]);
            last_d[i]  = lat_now[i];
`ifdef AP_PERF_MON_MAXLAT_EN
            max_d[i]   = (lat_now[i] > max_q[i]) ? lat_now[i] : max_q[i];
`endif
            cur_d[i]   = CNT_W'(1);
            state_d[i] = !ap_continue[i] ? HOLD : (run[i] && ap_start[i]) ? RUN : IDLE;
          end
        end else if (state_q[i] == HOLD && ap_continue[i]) begin
          state_d[i] = IDLE;
        end
      end
    end
  end

  // Readback mux over pre-update values
  always_comb begin
    ch_ok      = 32'(rd_ch) < NUM_CH;
    sel_val    = rd_sel == 3'd0 ? inv_q[rd_ch] :
                 rd_sel == 3'd1 ? busy_q[rd_ch] :
                 rd_sel == 3'd2 ? stl_q[rd_ch] :
                 rd_sel == 3'd3 ? iter_q[rd_ch] :
                 rd_sel == 3'd4 ? last_q[rd_ch] :
`ifdef AP_PERF_MON_MAXLAT_EN
                 rd_sel == 3'd5 ? max_q[rd_ch] :
`endif
                 rd_sel == 3'd6 ? CNT_W'(state_q[rd_ch]) : '0;
    rd_valid_d = rd_req;
    rd_data_d  = (rd_req && ch_ok) ? sel_val : '0;
  end

  // State registers
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_q[i] <= reset ? IDLE : state_d[i];
      inv_q[i]   <= reset ? '0 : inv_d[i];
      busy_q[i]  <= reset ? '0 : busy_d[i];
      stl_q[i]   <= reset ? '0 : stl_d[i];
      iter_q[i]  <= reset ? '0 : iter_d[i];
      last_q[i]  <= reset ? '0 : last_d[i];
      cur_q[i]   <= reset ? '0 : cur_d[i];
`ifdef AP_PERF_MON_MAXLAT_EN
      max_q[i]   <= reset ? '0 : max_d[i];
`endif
    end
    rd_valid_q <= reset ? 1'b0 : rd_valid_d;
    rd_data_q  <= reset ? '0 : rd_data_d;
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
endmodule
